// File: rtl/btn_event_conditioner.sv
// Per-button synchroniser, debouncer and press/release pulse generator.
// Optional hold-to-repeat press pulses are built when BTN_AUTOREPEAT_EN is defined.
module btn_event_conditioner #(
    parameter int N_BTN         = 4,
    parameter int DEBOUNCE_CYC  = 512,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);
`endif

    if (DEBOUNCE_CYC < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_event_conditioner: DEBOUNCE_CYC must be >= 2 and repeat timings >= 1");
    end

    typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_t;

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync_reg;
    logic [N_BTN-1:0] accept;
    logic [N_BTN-1:0] drop;
    logic [N_BTN-1:0] level_next;
    logic             any_held_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync_reg  <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync_reg  <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;
            logic             press_reg;
            logic             release_reg;

            // Accept/drop are shared with the any_held flop so it tracks btn_level exactly.
            assign accept[gi]     = (state_reg == ARM) && sync_reg[gi] && (cnt_reg == CNT_MAX);
            assign drop[gi]       = (state_reg == DISARM) && !sync_reg[gi] && (cnt_reg == CNT_MAX);
            assign level_next[gi] = (level_reg | accept[gi]) & ~drop[gi];

`ifdef BTN_AUTOREPEAT_EN
            logic [RPT_W-1:0] rpt_reg;
            logic             first_done_reg;
            logic             rpt_hit;
            // Pulse on the cycle the timer reaches its target, then restart from zero.
            assign rpt_hit = (rpt_reg + RPT_ONE) == (first_done_reg ? RPT_PERIOD_V : RPT_DELAY_V);
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg      <= IDLE;
                    cnt_reg        <= '0;
                    level_reg      <= 1'b0;
                    press_reg      <= 1'b0;
                    release_reg    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_reg        <= '0;
                    first_done_reg <= 1'b0;
`endif
                end else begin
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    case (state_reg)
                        IDLE: begin
                            if (sync_reg[gi]) begin
                                state_reg <= ARM;
                                cnt_reg   <= CNT_ONE;
                            end
                        end
                        ARM: begin
                            if (!sync_reg[gi]) begin
                                state_reg <= IDLE;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_MAX) begin
                                state_reg <= HELD;
                                cnt_reg   <= '0;
                                level_reg <= 1'b1;
                                press_reg <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                                rpt_reg        <= '0;
                                first_done_reg <= 1'b0;
`endif
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end
                        HELD: begin
                            if (!sync_reg[gi]) begin
                                state_reg <= DISARM;
                                cnt_reg   <= CNT_ONE;
                            end
`ifdef BTN_AUTOREPEAT_EN
                            else if (rpt_hit) begin
                                press_reg      <= 1'b1;
                                rpt_reg        <= '0;
                                first_done_reg <= 1'b1;
                            end else begin
                                rpt_reg <= rpt_reg + RPT_ONE;
                            end
`endif
                        end
                        DISARM: begin
                            // The repeat timer stays frozen here so a short glitch resumes it.
                            if (sync_reg[gi]) begin
                                state_reg <= HELD;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_MAX) begin
                                state_reg   <= IDLE;
                                cnt_reg     <= '0;
                                level_reg   <= 1'b0;
                                release_reg <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                                rpt_reg        <= '0;
                                first_done_reg <= 1'b0;
`endif
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_held_reg <= 1'b0;
        end else begin
            any_held_reg <= |level_next;
        end
    end

    assign any_held = any_held_reg;

endmodule
